// File: rtl/des_round_sequencer_if.sv
// Control bundle between the DES round sequencer and its datapath and consumer.
// The master side drives job starts and result acceptance; the slave side is the sequencer.
interface des_round_sequencer_if;
  logic       start_valid_i;
  logic       mode_i;
  logic       start_ready_o;
  logic       load_o;
  logic       round_en_o;
  logic [3:0] round_idx_o;
  logic [1:0] shift_amt_o;
  logic       shift_dir_o;
  logic       final_o;
  logic       out_valid_o;
  logic       out_ready_i;
  logic       busy_o;

  modport master (
    output start_valid_i, mode_i, out_ready_i,
    input  start_ready_o, load_o, round_en_o, round_idx_o, shift_amt_o,
           shift_dir_o, final_o, out_valid_o, busy_o
  );

  modport slave (
    input  start_valid_i, mode_i, out_ready_i,
    output start_ready_o, load_o, round_en_o, round_idx_o, shift_amt_o,
           shift_dir_o, final_o, out_valid_o, busy_o
  );
endinterface

// File: rtl/des_round_sequencer.sv
// DES round sequencer: LOAD, 16 ROUND, FINAL, then DONE; 18 cycles from accept to out_valid_o.
// Result held in DONE until out_ready_i; starts are refused (start_ready_o low) while busy.
module des_round_sequencer #(
  parameter int ROUNDS = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  des_round_sequencer_if.slave         bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       mode_q, mode_d;
  logic [1:0] shift_amt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (bus.start_valid_i) begin
          state_d = LOAD;
          mode_d  = bus.mode_i;
        end
      end
      LOAD: begin
        state_d = ROUND;
        cnt_d   = 4'd0;
      end
      ROUND: begin
        // Counter is cleared on exit rather than wrapping inside ROUND.
        if (cnt_q == LAST_ROUND) begin
          state_d = FINAL;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      FINAL: state_d = DONE;
      DONE: begin
        if (bus.out_ready_i) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Key schedule rotates by one in rounds 0, 1, 8 and 15, else by two.
  // Decryption starts from the unrotated key, so its round 0 shift is zero.
  always_comb begin
    shift_amt = 2'd0;
    if (state_q == ROUND) begin
      case (cnt_q)
        4'd0:    shift_amt = mode_q ? 2'd0 : 2'd1;
        4'd1,
        4'd8,
        4'd15:   shift_amt = 2'd1;
        default: shift_amt = 2'd2;
      endcase
    end
  end

  assign bus.start_ready_o = (state_q == IDLE);
  assign bus.load_o        = (state_q == LOAD);
  assign bus.round_en_o    = (state_q == ROUND);
  assign bus.round_idx_o   = (state_q == ROUND) ? cnt_q : 4'd0;
  assign bus.shift_amt_o   = shift_amt;
  assign bus.shift_dir_o   = mode_q;
  assign bus.final_o       = (state_q == FINAL);
  assign bus.out_valid_o   = (state_q == DONE);
  assign bus.busy_o        = (state_q != IDLE);

endmodule
